// File: rtl/minimips_pkg.sv
// minimips_pkg: shared ALU op encodings for the MiniMIPS datapath
package minimips_pkg;
  localparam int OP_W = 2;
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_RSV  = 2'b11
  } op_e;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: S-bit ripple-carry adder chained from full_adder cells
module adder_slice #(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         c_in,
  output logic [S-1:0] sum,
  output logic         c_out
);
  logic [S:0] c;
  assign c[0]  = c_in;
  assign c_out = c[S];
  for (genvar i = 0; i < S; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .sum  (sum[i]),
      .c_out(c[i+1])
    );
  end
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/sub/addc unit with the carry chain split over STAGES registered slices
module pipe_adder
  import minimips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic stall;
  logic unused_ok;
  if (WIDTH % STAGES != 0) begin : g_bad
    $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic             v_q, c_q, v_i, c_i, c_o;
    logic [WIDTH-1:0] a_q, b_q, s_q, a_i, b_i, s_i, s_d;
    logic [S-1:0]     sum;
    if (k == 0) begin : g_in
      assign v_i = in_valid;
      assign a_i = a;
      assign b_i = op == OP_SUB ? ~b : b;
      assign c_i = op == OP_SUB || (op == OP_ADDC && cin);
      assign s_i = '0;
    end else begin : g_mid
      assign v_i = g[k-1].v_q;
      assign a_i = g[k-1].a_q;
      assign b_i = g[k-1].b_q;
      assign c_i = g[k-1].c_q;
      assign s_i = g[k-1].s_q;
    end
    adder_slice #(.S(S)) u_slice (
      .a    (a_i[k*S +: S]),
      .b    (b_i[k*S +: S]),
      .c_in (c_i),
      .sum  (sum),
      .c_out(c_o)
    );
    // splice this slice's sum into the partial result carried down the pipe
    always_comb begin
      s_d = s_i;
      s_d[k*S +: S] = sum;
    end
    // stage register: holds everything while the output is stalled
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        c_q <= c_o;
        a_q <= a_i;
        b_q <= b_i;
        s_q <= s_d;
      end
    end
  end
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = g[L].v_q;
  assign result    = g[L].s_q;
  assign c_out     = g[L].c_q;
  assign overflow  = (g[L].a_q[WIDTH-1] == g[L].b_q[WIDTH-1]) && (result[WIDTH-1] != g[L].a_q[WIDTH-1]);
  assign zero      = ~|result;
  assign unused_ok = ^{g[L].a_q, g[L].b_q};
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors, stall/reset sequences and random runs on three pipe_adder configurations
module tb_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic        m_iv, m_ir, m_cin, m_ovld, m_ordy, m_c, m_ovf, m_z;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_op;
  logic        x_iv, x_ir, x_cin, x_ovld, x_ordy, x_c, x_ovf, x_z;
  logic [7:0]  x_a, x_b, x_res;
  logic [1:0]  x_op;
  logic        y_iv, y_ir, y_cin, y_ovld, y_ordy, y_c, y_ovf, y_z;
  logic [31:0] y_a, y_b, y_res;
  logic [1:0]  y_op;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_m (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b), .op(m_op), .cin(m_cin),
    .out_valid(m_ovld), .out_ready(m_ordy), .result(m_res), .c_out(m_c), .overflow(m_ovf), .zero(m_z));
  pipe_adder #(.WIDTH(8), .STAGES(2)) u_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_iv), .in_ready(x_ir), .a(x_a), .b(x_b), .op(x_op), .cin(x_cin),
    .out_valid(x_ovld), .out_ready(x_ordy), .result(x_res), .c_out(x_c), .overflow(x_ovf), .zero(x_z));
  pipe_adder #(.WIDTH(32), .STAGES(1)) u_y (
    .clk(clk), .rst_n(rst_n), .in_valid(y_iv), .in_ready(y_ir), .a(y_a), .b(y_b), .op(y_op), .cin(y_cin),
    .out_valid(y_ovld), .out_ready(y_ordy), .result(y_res), .c_out(y_c), .overflow(y_ovf), .zero(y_z));

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] r;
    logic        c, v, z;
  } vec_t;
  typedef struct {
    logic [34:0] e;
    int          t;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  function automatic logic [34:0] gold(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                       input logic cin, input int w);
    logic [32:0] mm, t;
    logic [31:0] m, aa, bb, r;
    logic        ci, c, ov;
    mm = (33'h1 << w) - 33'h1;
    m  = mm[31:0];
    aa = a & m;
    bb = (op == 2'b01 ? ~b : b) & m;
    ci = op == 2'b01 ? 1'b1 : (op == 2'b10 ? cin : 1'b0);
    t  = {1'b0, aa} + {1'b0, bb} + {32'b0, ci};
    r  = t[31:0] & m;
    c  = t[w];
    ov = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {c, ov, r == 32'b0, r};
  endfunction

  vec_t        tv[12];
  logic [31:0] sa[8], sb[8];
  logic [1:0]  sop[8];
  logic        scin[8];
  logic [34:0] se[8];
  exp_t        q8[$], q1[$];
  exp_t        e;

  initial begin
    int lat, sent, got, n8, n1;
    logic seen;
    tv = '{
      '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'h00000005, 32'h00000007, 2'b01, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
      '{32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
      '{32'h00000001, 32'h00000001, 2'b10, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0},
      '{32'h00000001, 32'h00000001, 2'b00, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0},
      '{32'h00000001, 32'h00000001, 2'b11, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0},
      '{32'h00000007, 32'h00000005, 2'b01, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0},
      '{32'h80000000, 32'h00000001, 2'b01, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
      '{32'h00000005, 32'h00000005, 2'b01, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'hFFFFFFFF, 32'h00000000, 2'b10, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'h12345678, 32'h11111111, 2'b00, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0},
      '{32'h80000000, 32'h80000000, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1}
    };
    {m_iv, m_cin, m_a, m_b, m_op} = '0;
    {x_iv, x_cin, x_a, x_b, x_op} = '0;
    {y_iv, y_cin, y_a, y_b, y_op} = '0;
    m_ordy = 1'b1; x_ordy = 1'b1; y_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(m_ovld), 0);
    chk("rst result", 64'(m_res), 0);
    chk("rst c_out", 64'(m_c), 0);
    chk("rst overflow", 64'(m_ovf), 0);
    chk("rst zero", 64'(m_z), 1);
    chk("rst in_ready", 64'(m_ir), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      m_a = tv[i].a; m_b = tv[i].b; m_op = tv[i].op; m_cin = tv[i].cin; m_iv = 1'b1;
      @(posedge clk);
      #1 m_iv = 1'b0;
      lat = 1;
      while (!m_ovld && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("v%0d latency", i), 64'(lat), 4);
      chk($sformatf("v%0d result", i), 64'(m_res), 64'(tv[i].r));
      chk($sformatf("v%0d c_out", i), 64'(m_c), 64'(tv[i].c));
      chk($sformatf("v%0d overflow", i), 64'(m_ovf), 64'(tv[i].v));
      chk($sformatf("v%0d zero", i), 64'(m_z), 64'(tv[i].z));
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sop[i] = 2'($urandom_range(0, 3)); scin[i] = 1'($urandom);
      se[i] = gold(sa[i], sb[i], sop[i], scin[i], 32);
    end
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      m_ordy = !(cyc >= 5 && cyc < 8);
      m_iv = sent < 8;
      if (sent < 8) begin
        m_a = sa[sent]; m_b = sb[sent]; m_op = sop[sent]; m_cin = scin[sent];
      end
      @(negedge clk);
      chk($sformatf("stall in_ready c%0d", cyc), 64'(m_ir), 64'(!(cyc >= 5 && cyc < 8)));
      if (m_ovld && m_ordy) begin
        chk($sformatf("stall op%0d", got), 64'({m_c, m_ovf, m_z, m_res}), 64'(se[got]));
        got++;
      end
      if (m_iv && m_ir) sent++;
      @(posedge clk);
      #1;
    end
    chk("stall ops out", 64'(got), 8);
    chk("stall ops in", 64'(sent), 8);
    m_iv = 1'b0;
    m_ordy = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= m_ovld;
    end
    chk("stall no extra", 64'(seen), 0);

    @(posedge clk);
    #1;
    repeat (4) begin
      m_a = $urandom; m_b = $urandom; m_op = 2'($urandom_range(0, 3)); m_iv = 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    m_a = 32'h1; m_b = 32'h1; m_op = 2'b00;
    @(posedge clk);
    #1;
    chk("mid rst out_valid", 64'(m_ovld), 0);
    chk("mid rst result", 64'(m_res), 0);
    chk("mid rst in_ready", 64'(m_ir), 1);
    chk("mid rst zero", 64'(m_z), 1);
    rst_n = 1'b1;
    m_iv = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= m_ovld;
    end
    chk("mid rst nothing emitted", 64'(seen), 0);

    @(posedge clk);
    #1;
    n8 = 0;
    n1 = 0;
    for (int cyc = 0; cyc < 1010; cyc++) begin
      x_iv = cyc < 1000; y_iv = cyc < 1000;
      x_a = 8'($urandom); x_b = 8'($urandom); x_op = 2'($urandom_range(0, 3)); x_cin = 1'($urandom);
      y_a = $urandom; y_b = $urandom; y_op = 2'($urandom_range(0, 3)); y_cin = 1'($urandom);
      @(negedge clk);
      if (x_ovld) begin
        if (q8.size() == 0) fail("w8 spurious output");
        else begin
          e = q8.pop_front();
          chk($sformatf("w8 op%0d", n8), 64'({x_c, x_ovf, x_z, 24'b0, x_res}), 64'(e.e));
          chk($sformatf("w8 lat%0d", n8), 64'(cnt - e.t), 2);
          n8++;
        end
      end
      if (y_ovld) begin
        if (q1.size() == 0) fail("s1 spurious output");
        else begin
          e = q1.pop_front();
          chk($sformatf("s1 op%0d", n1), 64'({y_c, y_ovf, y_z, y_res}), 64'(e.e));
          chk($sformatf("s1 lat%0d", n1), 64'(cnt - e.t), 1);
          n1++;
        end
      end
      if (x_iv && x_ir) q8.push_back('{gold({24'b0, x_a}, {24'b0, x_b}, x_op, x_cin, 8), cnt});
      if (y_iv && y_ir) q1.push_back('{gold(y_a, y_b, y_op, y_cin, 32), cnt});
      @(posedge clk);
      #1;
    end
    chk("w8 count", 64'(n8), 1000);
    chk("s1 count", 64'(n1), 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit that generalises the 32-bit ripple-carry adder into a WIDTH-bit adder whose carry chain is split into STAGES registered slices. It accepts one operation per cycle through a valid/ready handshake, supports add, subtract and add-with-carry, and produces carry, signed-overflow and zero flags. It sits between the MiniMIPS operand-fetch stage and write-back, as the ALU's add path and branch-compare path.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth, 1..WIDTH; each stage resolves WIDTH/STAGES bits of the carry chain.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- in_valid  in  1  operation present on a, b, op, cin.
- in_ready  out  1  unit can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD (A+B), 01 SUB (A+~B+1), 10 ADDC (A+B+cin), 11 reserved, executes as ADD.
- cin  in  1  carry-in, used only for ADDC.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1; for SUB, 1 = no borrow (A >= B unsigned).
- overflow  out  1  signed overflow: operand signs (after B inversion for SUB) equal, result sign differs.
- zero  out  1  result == 0.

## Operation
- Accept when in_valid && in_ready. Effective B = ~b for SUB, b otherwise; effective carry-in = 1 for SUB, cin for ADDC, 0 otherwise.
- Slice width S = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*S +: S] of A and effective B with the carry registered from stage k-1 (stage 0 uses effective carry-in).
- Each stage register holds: valid bit, completed low result bits, untouched high operand bits (skew), slice carry, sign bits of A/effective B for overflow.
- Flags computed combinationally from the final stage register; zero over full WIDTH result.
- Stall: stall = out_valid && !out_ready. On stall every stage register holds; in_ready = !stall. No bubble collapsing; ordering strictly FIFO.
- Reserved op 11 behaves exactly as ADD; no error output.
- Reset: all stage valid bits 0, all data registers 0. Hence out_valid=0, result=0, c_out=0, overflow=0, zero=1 (result zero) from the cycle after rst_n sampled low; in_ready=1.
- Reset mid-operation: all in-flight operations discarded, none emitted after reset; reset dominates a simultaneous accept.

## Timing
- Latency: operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES cycles including accept cycle), assuming no stall.
- Throughput: one op per cycle with out_ready held high.
- Each stall cycle adds one cycle to latency of every op in flight.
- Output handshake completes on edge where out_valid && out_ready; same edge may advance a new op into the final stage.
- Critical path: one S-bit ripple slice plus mux; no combinational path from out_ready to data, only to in_ready and stage enables.

## Structure
- Shared package minimips_pkg: op encodings (OP_ADD, OP_SUB, OP_ADDC), op width constant.
- Sub-module adder_slice (parameter S): S-bit ripple adder built from the existing full_adder cells, ports a, b, c_in, sum, c_out; instantiated STAGES times via generate.
- Elaboration check: WIDTH % STAGES == 0, else fatal.

## Test plan
- Default params, ADD 0xFFFFFFFF + 0x00000001 -> after 4 cycles result 0x00000000, c_out 1, zero 1, overflow 0.
- SUB 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, c_out 0, overflow 0, zero 0; ADD 0x7FFFFFFF + 1 -> 0x80000000, overflow 1.
- ADDC 0x00000001 + 0x00000001, cin 1 -> 0x00000003; same with op ADD, cin 1 -> 0x00000002 (cin ignored).
- 8 back-to-back random ops, out_ready low for 3 cycles mid-stream -> in_ready low exactly those cycles, all 8 results in order, none lost or duplicated, matched against golden model.
- Pipe full, rst_n low one cycle -> next cycle out_valid 0, result 0, in_ready 1; no pre-reset op ever emitted.
- WIDTH=8, STAGES=2 and WIDTH=32, STAGES=1: 1000 random ops vs golden model, latency exactly STAGES cycles.
